// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the NI injection path: flit-type encoding and framing states.
// The flit type sits in the IDENTIFIER_BITS MSBs of every flit.
package noc_flit_pkg;

    localparam int IDENTIFIER_BITS = 2;

    typedef enum logic [1:0] {
        FLIT_ILLEGAL = 2'b00,
        FLIT_HEAD    = 2'b01,
        FLIT_BODY    = 2'b10,
        FLIT_TAIL    = 2'b11
    } flit_type_e;

    typedef enum logic {
        FR_IDLE   = 1'b0,
        FR_IN_PKT = 1'b1
    } frame_state_e;

    function automatic flit_type_e get_flit_type(input logic [IDENTIFIER_BITS-1:0] id);
        return flit_type_e'(id);
    endfunction

endpackage

// File: rtl/ni_vc_fifo.sv
// Single-clock FIFO holding the flits of one VC plane.
// Latency: a pushed word is at the head one cycle later; head is combinational from state.
// Backpressure: push ignored when full, pop ignored when empty; no pass-through.
module ni_vc_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_vc_injection_buffer.sv
// NI injection stage: per-VC FIFOs between node and router, with wormhole framing checks and tail counters.
// Latency: flit visible one cycle after push, on the next slot where vc_sel selects its VC.
// Backpressure: ready_in drops when the selected VC FIFO is full; router stalls via ready_out.
module ni_vc_injection_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int VC              = 4,
    parameter int DEPTH           = 4,
    parameter int IDENTIFIER_BITS = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(VC)-1:0]                 vc_sel,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  valid_out,
    input  logic                                  ready_out,
    output logic [VC*($clog2(DEPTH)+1)-1:0]       occupancy,
    output logic [VC*CNT_WIDTH-1:0]               pkts_forwarded,
    output logic [VC-1:0]                         framing_err
);
    import noc_flit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [VC-1:0]         full;
    logic [VC-1:0]         empty;
    logic [VC-1:0]         push_v;
    logic [VC-1:0]         pop_v;
    logic [DATA_WIDTH-1:0] head  [VC];
    logic [CW-1:0]         count [VC];
    logic [CNT_WIDTH-1:0]  pkt_cnt [VC];
    frame_state_e          fr_state [VC];
    flit_type_e            in_type;

    assign ready_in  = !full[vc_sel];
    assign valid_out = !empty[vc_sel];
    assign data_out  = valid_out ? head[vc_sel] : '0;
    assign in_type   = get_flit_type(data_in[DATA_WIDTH-1 -: IDENTIFIER_BITS]);

    always_comb begin
        push_v         = '0;
        pop_v          = '0;
        push_v[vc_sel] = valid_in && ready_in;
        pop_v[vc_sel]  = valid_out && ready_out;
    end

    for (genvar k = 0; k < VC; k++) begin : g_vc
        ni_vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_v[k]),
            .push_data (data_in),
            .pop       (pop_v[k]),
            .pop_data  (head[k]),
            .full      (full[k]),
            .empty     (empty[k]),
            .count     (count[k])
        );
    end

    always_comb begin
        occupancy      = '0;
        pkts_forwarded = '0;
        for (int k = 0; k < VC; k++) begin
            occupancy[k*CW +: CW]             = count[k];
            pkts_forwarded[k*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[k];
        end
    end

    // Malformed flits only flag the error; they are still enqueued and forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            framing_err <= '0;
            for (int k = 0; k < VC; k++) begin
                fr_state[k] <= FR_IDLE;
                pkt_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < VC; k++) begin
                if (push_v[k]) begin
                    case (in_type)
                        FLIT_HEAD: begin
                            if (fr_state[k] == FR_IN_PKT) framing_err[k] <= 1'b1;
                            fr_state[k] <= FR_IN_PKT;
                        end
                        FLIT_BODY: begin
                            if (fr_state[k] == FR_IDLE) framing_err[k] <= 1'b1;
                        end
                        FLIT_TAIL: begin
                            if (fr_state[k] == FR_IDLE) framing_err[k] <= 1'b1;
                            fr_state[k] <= FR_IDLE;
                        end
                        default: begin
                            framing_err[k] <= 1'b1;
                            fr_state[k]    <= FR_IDLE;
                        end
                    endcase
                end
                if (pop_v[k] && get_flit_type(head[k][DATA_WIDTH-1 -: IDENTIFIER_BITS]) == FLIT_TAIL) begin
                    pkt_cnt[k] <= pkt_cnt[k] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ni_vc_injection_buffer.sv
// Directed plus randomized bench for ni_vc_injection_buffer against a queue-based reference model.
module tb_ni_vc_injection_buffer;
    localparam int DW    = 32;
    localparam int VC    = 4;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;
    localparam int OW    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        vc_sel;
    logic [DW-1:0]     data_in;
    logic              valid_in;
    logic              ready_in;
    logic [DW-1:0]     data_out;
    logic              valid_out;
    logic              ready_out;
    logic [VC*OW-1:0]  occupancy;
    logic [VC*CNTW-1:0] pkts_forwarded;
    logic [VC-1:0]     framing_err;

    always #5 clk = ~clk;

    ni_vc_injection_buffer #(
        .DATA_WIDTH (DW), .VC (VC), .DEPTH (DEPTH), .IDENTIFIER_BITS (2), .CNT_WIDTH (CNTW)
    ) dut (
        .clk (clk), .rst (rst), .vc_sel (vc_sel), .data_in (data_in), .valid_in (valid_in),
        .ready_in (ready_in), .data_out (data_out), .valid_out (valid_out), .ready_out (ready_out),
        .occupancy (occupancy), .pkts_forwarded (pkts_forwarded), .framing_err (framing_err)
    );

    // Reference model: one queue per VC, packet-open flag, sticky error, tail counter.
    logic [DW-1:0]   q [VC][$];
    bit              in_pkt [VC];
    bit              err_m  [VC];
    logic [CNTW-1:0] cnt_m  [VC];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < VC; k++) begin
            q[k].delete();
            in_pkt[k] = 0;
            err_m[k]  = 0;
            cnt_m[k]  = '0;
        end
    endtask

    task automatic check_outputs();
        int            v;
        logic [63:0]   occ_e;
        logic [63:0]   pkt_e;
        logic [63:0]   err_e;
        v     = int'(vc_sel);
        occ_e = '0;
        pkt_e = '0;
        err_e = '0;
        for (int k = 0; k < VC; k++) begin
            occ_e[k*OW +: OW]     = OW'(q[k].size());
            pkt_e[k*CNTW +: CNTW] = cnt_m[k];
            err_e[k]              = err_m[k];
        end
        chk("ready_in",  64'(ready_in),  64'(q[v].size() < DEPTH));
        chk("valid_out", 64'(valid_out), 64'(q[v].size() > 0));
        chk("data_out",  64'(data_out),  (q[v].size() > 0) ? 64'(q[v][0]) : 64'd0);
        chk("occupancy", 64'(occupancy), occ_e);
        chk("pkts_fwd",  pkts_forwarded, pkt_e);
        chk("framing",   64'(framing_err), err_e);
    endtask

    task automatic step(input int vc, input bit vin, input logic [DW-1:0] din, input bit rout);
        bit          push_ok;
        bit          pop_ok;
        logic [DW-1:0] t;
        vc_sel    = 2'(vc);
        valid_in  = vin;
        data_in   = din;
        ready_out = rout;
        #1;
        check_outputs();
        push_ok = vin && (q[vc].size() < DEPTH);
        pop_ok  = rout && (q[vc].size() > 0);
        @(posedge clk);
        if (pop_ok) begin
            t = q[vc].pop_front();
            if (t[DW-1 -: 2] == 2'b11) cnt_m[vc] = cnt_m[vc] + 1'b1;
        end
        if (push_ok) begin
            q[vc].push_back(din);
            case (din[DW-1 -: 2])
                2'b01:   begin if (in_pkt[vc]) err_m[vc] = 1; in_pkt[vc] = 1; end
                2'b10:   begin if (!in_pkt[vc]) err_m[vc] = 1; end
                2'b11:   begin if (!in_pkt[vc]) err_m[vc] = 1; in_pkt[vc] = 0; end
                default: begin err_m[vc] = 1; in_pkt[vc] = 0; end
            endcase
        end
        @(negedge clk);
    endtask

    // Rotate the selector; only the target VC's slot carries the push.
    task automatic run(input int target, input bit vin, input logic [DW-1:0] din, input bit rout);
        for (int i = 0; i < VC; i++) begin
            int v;
            v   = cyc % VC;
            cyc = cyc + 1;
            if (v == target) begin
                step(v, vin, din, rout);
                return;
            end
            step(v, 1'b0, '0, rout);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]    id;
        int            ty;
        vc_sel    = '0;
        data_in   = '0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        do_reset();

        // Idle after reset with a rotating selector.
        for (int i = 0; i < 4; i++) step(i, 1'b0, '0, 1'b0);
        chk("rst_ready_in", 64'(ready_in), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);

        // One well-formed packet on VC2, drained on VC2 slots.
        run(2, 1'b1, 32'h4000_0005, 1'b1);
        run(2, 1'b1, 32'h8000_0000, 1'b1);
        run(2, 1'b1, 32'hC000_0005, 1'b1);
        run(2, 1'b0, '0, 1'b1);
        run(2, 1'b0, '0, 1'b1);
        chk("vc2_pkts", 64'(pkts_forwarded[2*CNTW +: CNTW]), 64'd1);
        chk("vc2_err", 64'(framing_err), 64'd0);

        // Fill VC1 with the router stalled; the fifth push is refused.
        run(1, 1'b1, 32'h4000_0011, 1'b0);
        run(1, 1'b1, 32'h8000_0012, 1'b0);
        run(1, 1'b1, 32'h8000_0013, 1'b0);
        run(1, 1'b1, 32'hC000_0014, 1'b0);
        chk("vc1_occ_full", 64'(occupancy[1*OW +: OW]), 64'd4);
        run(1, 1'b1, 32'h4000_0015, 1'b0);
        chk("vc1_fifth_refused", 64'(ready_in), 64'd0);
        chk("vc1_occ_still4", 64'(occupancy[1*OW +: OW]), 64'd4);

        // Full FIFO: simultaneous push/pop pops only.
        run(1, 1'b1, 32'h4000_0016, 1'b1);
        chk("vc1_full_pushpop", 64'(occupancy[1*OW +: OW]), 64'd3);
        for (int i = 0; i < 3; i++) run(1, 1'b0, '0, 1'b1);
        chk("vc1_drained", 64'(occupancy[1*OW +: OW]), 64'd0);
        chk("vc1_pkts", 64'(pkts_forwarded[1*CNTW +: CNTW]), 64'd1);

        // Stray body on idle VC3 sets a sticky error but is still forwarded.
        run(3, 1'b1, 32'h8000_0001, 1'b1);
        chk("vc3_err_set", 64'(framing_err[3]), 64'd1);
        run(3, 1'b0, '0, 1'b1);
        run(3, 1'b1, 32'h4000_0031, 1'b1);
        run(3, 1'b1, 32'hC000_0032, 1'b1);
        run(3, 1'b0, '0, 1'b1);
        run(3, 1'b0, '0, 1'b1);
        chk("vc3_err_sticky", 64'(framing_err[3]), 64'd1);

        // Reset with VC0 partially filled discards everything.
        run(0, 1'b1, 32'h4000_0001, 1'b0);
        run(0, 1'b1, 32'h8000_0002, 1'b0);
        chk("vc0_occ2", 64'(occupancy[0 +: OW]), 64'd2);
        do_reset();
        step(0, 1'b0, '0, 1'b0);
        chk("post_rst_occ", 64'(occupancy), 64'd0);
        chk("post_rst_valid", 64'(valid_out), 64'd0);
        chk("post_rst_pkts", pkts_forwarded, 64'd0);
        chk("post_rst_err", 64'(framing_err), 64'd0);

        // Randomized traffic with a random selector.
        for (int i = 0; i < 3000; i++) begin
            ty = int'($urandom_range(0, 9));
            id = (ty == 0) ? 2'b00 : (ty < 4) ? 2'b01 : (ty < 7) ? 2'b10 : 2'b11;
            step(int'($urandom_range(0, VC-1)), 1'($urandom_range(0, 1)),
                 {id, 30'($urandom)}, ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
